// File: rtl/enc_pwm_pkg.sv
// enc_pwm_pkg: quadrature states, direction codes, decode helper
// shared by enc_pwm_channel and enc_pwm_array
package enc_pwm_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_UP,
    DIR_DOWN,
    DIR_ERR
  } dir_t;

  // {A,B} history -> direction; A leading B counts up
  function automatic dir_t quad_decode(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    dir_t d;
    d = DIR_NONE;
    if (prev == cur) begin
      d = DIR_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      d = DIR_ERR;
    end else begin
      unique case (prev)
        Q00: d = (cur == Q10) ? DIR_UP : DIR_DOWN;
        Q10: d = (cur == Q11) ? DIR_UP : DIR_DOWN;
        Q11: d = (cur == Q01) ? DIR_UP : DIR_DOWN;
        Q01: d = (cur == Q00) ? DIR_UP : DIR_DOWN;
        default: d = DIR_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/enc_pwm_channel.sv
// enc_pwm_channel: one encoder->PWM lane (sync, x4 decode, duty, PWM, err)
// ports: clk/reset, enc_a/enc_b pins, prime, cnt, err_clr -> pwm, duty, err
import enc_pwm_pkg::*;

module enc_pwm_channel #(
  parameter int PWM_W       = 8,
  parameter int STEP        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             prime,
  input  logic [PWM_W-1:0] cnt,
  input  logic             err_clr,
  output logic             pwm,
  output logic [PWM_W-1:0] duty,
  output logic             err
);

  localparam logic [PWM_W:0] MAX_W  =
    {1'b0, {PWM_W{1'b1}}};
  localparam logic [PWM_W:0] STEP_W =
    (PWM_W+1)'(STEP);

  logic [SYNC_STAGES-1:0] sa;
  logic [SYNC_STAGES-1:0] sb;
  logic [1:0]             cur;
  logic [1:0]             prev_ab;
  logic [PWM_W-1:0]       shadow;
  logic [PWM_W-1:0]       eff;
  logic [PWM_W-1:0]       duty_nxt;
  logic [PWM_W:0]         up_sum;
  logic [PWM_W:0]         dn_diff;
  dir_t                   dir;

  assign cur = {sa[SYNC_STAGES-1], sb[SYNC_STAGES-1]};

  // period boundary takes the live duty so the new value
  // lines up with the first count of the period
  assign eff = (cnt == '0) ? duty : shadow;

  always_comb begin
    dir      = DIR_NONE;
    duty_nxt = duty;
    up_sum   = {1'b0, duty} + STEP_W;
    dn_diff  = {1'b0, duty} - STEP_W;
    if (!prime) begin
      dir = quad_decode(prev_ab, cur);
    end
    unique case (dir)
      DIR_UP: begin
        if (up_sum > MAX_W) duty_nxt = MAX_W[PWM_W-1:0];
        else duty_nxt = up_sum[PWM_W-1:0];
      end
      DIR_DOWN: begin
        // borrow out of the wide subtract means underflow
        if (dn_diff[PWM_W]) duty_nxt = '0;
        else duty_nxt = dn_diff[PWM_W-1:0];
      end
      default: duty_nxt = duty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sa      <= '0;
      sb      <= '0;
      prev_ab <= '0;
      duty    <= '0;
      shadow  <= '0;
      pwm     <= 1'b0;
      err     <= 1'b0;
    end else begin
      sa      <= {sa[SYNC_STAGES-2:0], enc_a};
      sb      <= {sb[SYNC_STAGES-2:0], enc_b};
      prev_ab <= cur;
      duty    <= duty_nxt;
      shadow  <= eff;
      pwm     <= (cnt < eff);
      err     <= (err & ~err_clr) | (dir == DIR_ERR);
    end
  end

endmodule

// File: rtl/enc_pwm_array.sv
// enc_pwm_array: N-channel quadrature encoder to PWM controller
// ports: clk, reset(n), enc_a/enc_b, err_clr -> pwm_out, duty_o, err_o
import enc_pwm_pkg::*;

module enc_pwm_array #(
  parameter int CHANNELS    = 3,
  parameter int PWM_W       = 8,
  parameter int STEP        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       enc_a,
  input  logic [CHANNELS-1:0]       enc_b,
  input  logic                      err_clr,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic [CHANNELS*PWM_W-1:0] duty_o,
  output logic [CHANNELS-1:0]       err_o
);

  localparam int PCW = $clog2(SYNC_STAGES + 2);
  localparam logic [PCW-1:0] PRIME_INIT =
    PCW'(SYNC_STAGES + 1);
  localparam logic [PWM_W-1:0] CNT_LAST =
    {{(PWM_W-1){1'b1}}, 1'b0};

  logic [PCW-1:0]   prime_cnt;
  logic [PWM_W-1:0] cnt;
  logic             prime;

  assign prime = (prime_cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      prime_cnt <= PRIME_INIT;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (prime) prime_cnt <= prime_cnt - 1'b1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    enc_pwm_channel #(
      .PWM_W      (PWM_W),
      .STEP       (STEP),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .enc_a  (enc_a[i]),
      .enc_b  (enc_b[i]),
      .prime  (prime),
      .cnt    (cnt),
      .err_clr(err_clr),
      .pwm    (pwm_out[i]),
      .duty   (duty_o[i*PWM_W +: PWM_W]),
      .err    (err_o[i])
    );
  end

endmodule

// File: tb/tb_enc_pwm_array.sv
// tb_enc_pwm_array: directed checks of enc_pwm_array
// defaults: 3 channels, 8-bit duty, step 1, 2 sync stages
module tb_enc_pwm_array;

  localparam int CH = 3;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   enc_a;
  logic [CH-1:0]   enc_b;
  logic            err_clr;
  logic [CH-1:0]   pwm_out;
  logic [CH*W-1:0] duty_o;
  logic [CH-1:0]   err_o;

  int npass = 0;
  int ntot  = 0;
  int mcnt;
  int hi;
  int lows;
  logic [1:0] st0;
  logic [1:0] st1;

  enc_pwm_array #(
    .CHANNELS   (CH),
    .PWM_W      (W),
    .STEP       (1),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .err_clr(err_clr),
    .pwm_out(pwm_out),
    .duty_o (duty_o),
    .err_o  (err_o)
  );

  always #5 clk = ~clk;

  // reference period phase: 0..254
  always @(posedge clk) begin
    if (!reset) mcnt <= 0;
    else mcnt <= (mcnt == 254) ? 0 : mcnt + 1;
  end

  function automatic logic [1:0] up_nx(
    input logic [1:0] s
  );
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] dn_nx(
    input logic [1:0] s
  );
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] duty_of(
    input int ch
  );
    return 32'(duty_o[ch*W +: W]);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_enc(
    input int ch,
    input logic [1:0] ab
  );
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
  endtask

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d, want %0d",
                tag, obs, exp);
  endtask

  task automatic wait_cnt(input int v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      tick(1);
      if (mcnt == v) hit = 1'b1;
    end
    chk("wait_cnt", 32'(hit), 1);
  endtask

  task automatic count_high(
    input int ch,
    input int n,
    output int h
  );
    h = 0;
    repeat (n) begin
      tick(1);
      h += int'(pwm_out[ch]);
    end
  endtask

  initial begin
    reset   = 1'b0;
    enc_a   = '0;
    enc_b   = '0;
    err_clr = 1'b0;
    st0     = 2'b00;
    st1     = 2'b00;
    tick(3);
    chk("rst_duty", 32'(duty_o), 0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_err", 32'(err_o), 0);
    reset = 1'b1;
    tick(5);

    // 1: four up steps, 3-edge latency each
    for (int k = 1; k <= 4; k++) begin
      st0 = up_nx(st0);
      set_enc(0, st0);
      tick(2);
      chk("t1_pre", duty_of(0), 32'(k - 1));
      tick(1);
      chk("t1_post", duty_of(0), 32'(k));
    end
    chk("t1_others", 32'(duty_o[CH*W-1:W]), 0);

    // 2: down to 0 then floor
    for (int k = 0; k < 4; k++) begin
      st0 = dn_nx(st0);
      set_enc(0, st0);
      tick(3);
    end
    chk("t2_zero", duty_of(0), 0);
    for (int k = 0; k < 3; k++) begin
      st0 = dn_nx(st0);
      set_enc(0, st0);
      tick(3);
    end
    chk("t2_floor", duty_of(0), 0);
    tick(260);
    count_high(0, 255, hi);
    chk("t2_pwm_low", 32'(hi), 0);

    // 3: saturate at 255
    repeat (300) begin
      st0 = up_nx(st0);
      set_enc(0, st0);
      tick(1);
    end
    tick(3);
    chk("t3_sat", duty_of(0), 255);
    tick(260);
    count_high(0, 255, hi);
    chk("t3_pwm_high", 32'(hi), 255);

    // 4: 255 -> 64 inside one period
    wait_cnt(10);
    lows = 0;
    repeat (191) begin
      st0 = dn_nx(st0);
      set_enc(0, st0);
      tick(1);
      lows += int'(!pwm_out[0]);
    end
    tick(3);
    lows += int'(!pwm_out[0]);
    chk("t4_hold", 32'(lows), 0);
    chk("t4_duty", duty_of(0), 64);
    wait_cnt(1);
    chk("t4_ph0", 32'(pwm_out[0]), 1);
    wait_cnt(64);
    chk("t4_ph63", 32'(pwm_out[0]), 1);
    tick(1);
    chk("t4_ph64", 32'(pwm_out[0]), 0);
    count_high(0, 255, hi);
    chk("t4_pwm64", 32'(hi), 64);

    // 5: illegal jumps on ch1
    for (int k = 0; k < 4; k++) begin
      st1 = up_nx(st1);
      set_enc(1, st1);
      tick(3);
    end
    chk("t5_duty4", duty_of(1), 4);
    st1 = 2'b11;
    set_enc(1, st1);
    tick(3);
    chk("t5_err", 32'(err_o), 32'b010);
    chk("t5_hold", duty_of(1), 4);
    st1 = dn_nx(st1);
    set_enc(1, st1);
    tick(3);
    chk("t5_duty3", duty_of(1), 3);
    st1 = 2'b01;
    set_enc(1, st1);
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t5_err_wins", 32'(err_o), 32'b010);
    chk("t5_hold2", duty_of(1), 3);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t5_clr", 32'(err_o), 0);

    // 6: reset mid-period, ch2 held at 11
    wait_cnt(10);
    chk("t6_pre_pwm", 32'(pwm_out[0]), 1);
    reset = 1'b0;
    set_enc(2, 2'b11);
    tick(1);
    chk("t6_rst_pwm", 32'(pwm_out), 0);
    chk("t6_rst_duty", 32'(duty_o), 0);
    tick(2);
    reset = 1'b1;
    tick(10);
    chk("t6_no_cnt", 32'(duty_o), 0);
    chk("t6_no_err", 32'(err_o), 0);
    chk("t6_pwm0", 32'(pwm_out), 0);
    set_enc(2, 2'b01);
    tick(3);
    chk("t6_count", duty_of(2), 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
